// File: rtl/raster_blitter.sv
// Rectangle raster walker: scans a W x H sprite region row-major, drives the sprite ROM
// address and delays x/y/plot to line up with ROM data. Optional TRANSPARENT_EN gates plot by KEY_COLOUR.
module raster_blitter #(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int ADDR_W = 16,
    parameter int COLOUR_W = 3,
    parameter int ROM_LAT = 1,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [X_W:0] SCR_W = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W + 1)'(SCREEN_H);
    localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);
`ifdef TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    state_t state;
    logic [X_W-1:0] x0_r;
    logic [X_W-1:0] width_r;
    logic [X_W-1:0] col;
    logic [Y_W-1:0] y0_r;
    logic [Y_W-1:0] height_r;
    logic [Y_W-1:0] row;
    logic [1:0] drain_cnt;
    logic last_col;
    logic last_row;
    logic [X_W:0] xsum;
    logic [Y_W:0] ysum;

    logic [ROM_LAT-1:0] vld;
    logic [X_W:0] xs [ROM_LAT];
    logic [Y_W:0] ys [ROM_LAT];

    assign last_col = (col == width_r - 1'b1);
    assign last_row = (row == height_r - 1'b1);
    // One bit wider than the coordinate so off-screen pixels never wrap back into view
    assign xsum = {1'b0, x0_r} + {1'b0, col};
    assign ysum = {1'b0, y0_r} + {1'b0, row};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x0_r      <= '0;
            y0_r      <= '0;
            width_r   <= '0;
            height_r  <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        x0_r     <= x0;
                        y0_r     <= y0;
                        width_r  <= width;
                        height_r <= height;
                        col      <= '0;
                        row      <= '0;
                        if (width == '0 || height == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr <= base_addr;
                            busy     <= 1'b1;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_col && last_row) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        if (last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Delay line matching the ROM read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else if (abort && state != IDLE) begin
            vld <= '0;
        end else begin
            vld[0] <= (state == SCAN);
            xs[0]  <= xsum;
            ys[0]  <= ysum;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld[i] <= vld[i-1];
                xs[i]  <= xs[i-1];
                ys[i]  <= ys[i-1];
            end
        end
    end

    assign x      = xs[ROM_LAT-1][X_W-1:0];
    assign y      = ys[ROM_LAT-1][Y_W-1:0];
    assign colour = rom_data;
    assign plot   = vld[ROM_LAT-1] && (xs[ROM_LAT-1] < SCR_W) && (ys[ROM_LAT-1] < SCR_H)
                    && (!KEY_EN || rom_data != KEY_COLOUR);

endmodule

// File: tb/tb_raster_blitter.sv
// Directed self-checking bench for raster_blitter (ROM_LAT=1) with a registered sprite ROM model.
module tb_raster_blitter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  width;
    logic [7:0]  height;
    logic [15:0] base_addr;
    logic [15:0] rom_addr;
    logic [2:0]  rom_data;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks = 0;
    int fails = 0;

    raster_blitter dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .width(width), .height(height), .base_addr(base_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_fn(input logic [15:0] a);
        case (a)
            16'd200: return 3'd0;
            16'd201: return 3'd5;
            16'd202: return 3'd0;
            16'd203: return 3'd7;
            default: return a[2:0] ^ a[5:3];
        endcase
    endfunction

    always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a blit in the current cycle and checks every cycle through one past done.
    // A start with other operands is injected at cycle poke (if positive) and must be ignored.
    task automatic run_blit(input logic [8:0] bx0, input logic [7:0] by0, input logic [8:0] bw,
                            input logic [7:0] bh, input logic [15:0] bbase, input int poke);
        int n, last, p, ex, ey, exp_plots, got_plots;
        logic ep;
        logic [2:0] ecol;
        logic [15:0] eaddr;
        x0 = bx0; y0 = by0; width = bw; height = bh; base_addr = bbase; start = 1'b1;
        n = int'(bw) * int'(bh);
        last = 1 + n + LAT;
        exp_plots = 0;
        got_plots = 0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= last + 1; k++) begin
            if (k > 1) tick();
            if (k == poke) begin
                start = 1'b1; x0 = 9'd100; y0 = 8'd100; width = 9'd7; height = 8'd3; base_addr = 16'h7777;
            end else if (poke > 0 && k == poke + 1) begin
                start = 1'b0;
            end
            p = k - 1 - LAT;
            ep = 1'b0;
            ex = 0;
            ey = 0;
            ecol = 3'd0;
            if (p >= 0 && p < n) begin
                ex = int'(bx0) + p % int'(bw);
                ey = int'(by0) + p / int'(bw);
                ecol = rom_fn(bbase + 16'(p));
                ep = (ex < 320) && (ey < 240);
`ifdef TRANSPARENT_EN
                if (ecol == 3'd0) ep = 1'b0;
`endif
            end
            check("plot", {31'd0, plot}, {31'd0, ep});
            if (ep) begin
                exp_plots++;
                check("x", {23'd0, x}, ex);
                check("y", {24'd0, y}, ey);
                check("colour", {29'd0, colour}, {29'd0, ecol});
            end
            if (plot === 1'b1) got_plots++;
            check("done", {31'd0, done}, {31'd0, k == last});
            check("busy", {31'd0, busy}, {31'd0, k < last});
            eaddr = (k <= n) ? bbase + 16'(k - 1) : bbase + 16'(n - 1);
            check("rom_addr", {16'd0, rom_addr}, {16'd0, eaddr});
        end
        check("plot_count", got_plots, exp_plots);
    endtask

    // Linear directed sequence: reset, normal, clipping, ignored start, abort, zero size, key colour
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; width = '0; height = '0; base_addr = '0;
        #3;
        check("reset_rom_addr", {16'd0, rom_addr}, 32'd0);
        check("reset_x", {23'd0, x}, 32'd0);
        check("reset_y", {24'd0, y}, 32'd0);
        check("reset_plot", {31'd0, plot}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] basic 3x2 blit");
        run_blit(9'd10, 8'd20, 9'd3, 8'd2, 16'd100, -1);
        $display("[TB] clipping at screen corner");
        run_blit(9'd318, 8'd239, 9'd4, 8'd2, 16'd300, -1);
        $display("[TB] start while busy is ignored");
        run_blit(9'd0, 8'd0, 9'd320, 8'd1, 16'd1000, 50);

        $display("[TB] abort mid-blit");
        x0 = 9'd0; y0 = 8'd0; width = 9'd10; height = 8'd10; base_addr = 16'd500; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre_plot", {31'd0, plot}, 32'd1);
        check("abort_pre_x", {23'd0, x}, 32'd3);
        check("abort_pre_addr", {16'd0, rom_addr}, 32'd504);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_plot", {31'd0, plot}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_no_plot", {31'd0, plot}, 32'd0);
            tick();
        end
        run_blit(9'd4, 8'd4, 9'd2, 8'd1, 16'd2000, -1);

        $display("[TB] abort together with start in idle");
        x0 = 9'd1; y0 = 8'd1; width = 9'd2; height = 8'd2; base_addr = 16'd40;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_done", {31'd0, done}, 32'd0);
        check("idle_abort_addr", {16'd0, rom_addr}, 32'd2001);
        tick();
        check("idle_abort_busy2", {31'd0, busy}, 32'd0);

        $display("[TB] zero width region");
        x0 = 9'd0; y0 = 8'd0; width = 9'd0; height = 8'd5; base_addr = 16'd3333; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_plot", {31'd0, plot}, 32'd0);
        check("zero_addr", {16'd0, rom_addr}, 32'd2001);
        tick();
        check("zero_done_once", {31'd0, done}, 32'd0);
        check("zero_busy2", {31'd0, busy}, 32'd0);

        $display("[TB] key colour row");
        run_blit(9'd5, 8'd5, 9'd4, 8'd1, 16'd200, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/raster_blitter.md
Name: raster_blitter

Overview:
- Rectangle raster walker. Sits between the animation control FSM and the VGA adapter's pixel-write port, replacing hand-rolled X/Y/address counters in the datapath.
- On a start pulse it walks a W x H region at origin (x0, y0) row-major and drives the sprite ROM address.
- It re-aligns x/y/plot with the synchronous ROM's read latency, so colour, x and y reach the adapter in the same cycle.
- Clips pixels outside 320x240 and pulses done when the last pixel has been issued.

Parameters:
- X_W, 9, width of x coordinate / width operand
- Y_W, 8, width of y coordinate / height operand
- ADDR_W, 16, sprite ROM address width
- COLOUR_W, 3, pixel colour width
- ROM_LAT, 1, ROM read latency in clocks (1..3)
- SCREEN_W, 320, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 240, visible rows; y >= SCREEN_H is clipped
- KEY_COLOUR, 3'b000, transparent colour (used only with TRANSPARENT_EN)

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel of the current blit
- x0  in  X_W  region origin column
- y0  in  Y_W  region origin row
- width  in  X_W  region width in pixels
- height  in  Y_W  region height in pixels
- base_addr  in  ADDR_W  ROM address of the region's pixel (0,0)
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  COLOUR_W  ROM read data, valid ROM_LAT cycles after rom_addr
- x  out  X_W  pixel column to adapter
- y  out  Y_W  pixel row to adapter
- colour  out  COLOUR_W  pixel colour to adapter (= rom_data)
- plot  out  1  write enable to adapter
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high) state:
  - FSM = IDLE.
  - rom_addr = 0, x = 0, y = 0, plot = 0, busy = 0, done = 0.
  - All pipeline valid bits cleared.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - start=1 latches x0, y0, width, height and base_addr.
  - col = 0, row = 0, rom_addr <= base_addr.
  - If width==0 or height==0: go straight to done=1 on the next cycle, no plots, stay IDLE.
  - Otherwise go to SCAN with busy=1 from the next cycle.
- SCAN:
  - Each cycle issues one pixel: pipeline valid=1 with x0+col and y0+row.
  - Next cycle: rom_addr +1 (wraps mod 2^ADDR_W); col +1.
  - When col==width-1: col <= 0, row +1.
  - When col==width-1 and row==height-1: last pixel issued, go to DRAIN.
- Address arithmetic:
  - Coordinate sums are computed one bit wider than X_W / Y_W.
  - Clip test uses the wide sum; x/y outputs take the low X_W / Y_W bits.
- Pipeline:
  - valid, x and y pass through a ROM_LAT-deep shift register.
  - Outputs are x = x_d, y = y_d, plot = valid_d & (xsum_d < SCREEN_W) & (ysum_d < SCREEN_H).
  - colour = rom_data, combinational pass-through.
  - plot is never high for a clipped pixel.
- DRAIN:
  - Waits ROM_LAT cycles for the pipeline to empty.
  - Then done=1 for exactly one cycle, busy=0, return to IDLE.
  - done is coincident with busy falling.
- Latency:
  - start at cycle 0 gives the first rom_addr in cycle 1 and the first plot in cycle 1+ROM_LAT.
  - done falls in cycle 1+W*H+ROM_LAT.
- start while busy: ignored, parameters unchanged.
- abort while busy:
  - Next cycle: FSM to IDLE, pipeline valids cleared, plot=0, busy=0.
  - No done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start is ignored.
- Reset mid-blit: immediate return to reset values. No done pulse.
- Input operands may change freely after acceptance.

Optional Feature:
- TRANSPARENT_EN defined: plot is additionally gated by colour != KEY_COLOUR. Transparent pixels still consume their cycle and ROM address; timing is unchanged.
- TRANSPARENT_EN undefined: every in-screen pixel is plotted regardless of colour; KEY_COLOUR is unused.

Test Plan:
- ROM_LAT=1, x0=10, y0=20, W=3, H=2, base=100:
  - rom_addr 100..105 in cycles 1..6.
  - plot in cycles 2..7 at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour matching ROM model.
  - done in cycle 8 only.
- Clipping, x0=318, y0=239, W=4, H=2:
  - 8 addresses issued.
  - plot only for (318,239) and (319,239).
  - done at cycle 1+8+ROM_LAT.
- W=0, H=5, start:
  - No rom_addr change, no plot, busy stays 0.
  - done=1 in cycle 1.
- start pulse mid-blit (W=320, H=1): ignored; 320 plots; rom_addr ends at base+319.
- abort at the 5th SCAN cycle of W=10, H=10:
  - plot low from the next cycle, no done.
  - A new start then restarts at the new base_addr.
- With TRANSPARENT_EN, KEY_COLOUR=0, ROM row {0,5,0,7}:
  - plot only for the 2nd and 4th pixels.
  - done timing is identical to the non-transparent run.
